// File: rtl/slave_io_pkg.sv
// slave_io_pkg: shared constants and state type for the slave_io responder.
package slave_io_pkg;

    localparam logic [7:0] CMD_A5           = 8'hA5;
    localparam logic [7:0] CMD_C3           = 8'hC3;
    localparam logic [7:0] MASTER_IDLE      = 8'hFF;

    localparam logic [7:0] DEF_NACK_CODE    = 8'hFF;
    localparam logic [7:0] DEF_IDLE_CODE    = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        NACK
    } slave_state_t;

endpackage

// File: rtl/data_transfer.sv
// data_transfer: byte-wide master/slave link. The master drives mdata and the slave answers on sdata.
interface data_transfer #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] mdata;
    logic [DATA_W-1:0] sdata;

    modport master (output mdata, input sdata);
    modport slave  (input mdata, output sdata);
endinterface

// File: rtl/slave_fifo.sv
// slave_fifo: synchronous FIFO with a registered read port.
// The occupancy counter is the only source of full/empty.
// A pop is evaluated before a push, so a full FIFO that is popped in the same cycle still accepts the push.
module slave_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     push_ok,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int              PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count_q;
    logic              pop_ok;

    assign count   = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    // Pop first, then push: a pop that frees a slot lets the push in.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Pointer, occupancy and read-port registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples values from before the edge.
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_ok;
            if (pop_ok) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset. The counter and pointers decide which entries are valid, so resetting the array would only cost area.
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/slave_io.sv
// slave_io: responder end of the data_transfer link.
// It captures master bytes into slave_fifo and answers each capture on sdata with ~byte (ACK), NACK_CODE or IDLE_CODE.
// Optional build macro SLAVE_IO_CMD_COUNT_EN: adds saturating counters cnt_a5/cnt_c3 of accepted 0xA5/0xC3 bytes.
module slave_io
    import slave_io_pkg::*;
#(
    parameter int                 DEPTH     = 4,
    parameter int                 DATA_W    = 8,
    parameter logic [DATA_W-1:0]  NACK_CODE = DATA_W'(DEF_NACK_CODE),
    parameter logic [DATA_W-1:0]  IDLE_CODE = DATA_W'(DEF_IDLE_CODE)
) (
    input  logic                     clk,
    input  logic                     rst,
    data_transfer.slave              slave_transfer,
    input  logic                     sample_en,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
`ifdef SLAVE_IO_CMD_COUNT_EN
    ,
    output logic [7:0]               cnt_a5,
    output logic [7:0]               cnt_c3
`endif
);
    slave_state_t      state_q;
    logic [DATA_W-1:0] ack_q;
    logic [DATA_W-1:0] mdata;
    logic [DATA_W-1:0] sdata;
    logic              push_req;
    logic              push_ok;
    logic              refused;

    assign mdata    = slave_transfer.mdata;
    // The master's idle/reset pattern is never stored.
    assign push_req = sample_en && (mdata != DATA_W'(MASTER_IDLE));
    assign refused  = push_req && !push_ok;

    slave_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_req),
        .pop      (rd_en),
        .wr_data  (mdata),
        .push_ok  (push_ok),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // Response FSM: remembers the outcome of this cycle's capture for one cycle. The overflow flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ack_q    <= '0;
            overflow <= 1'b0;
        end else if (push_ok) begin
            state_q  <= ACK;
            ack_q    <= mdata;
        end else if (refused) begin
            state_q  <= NACK;
            overflow <= 1'b1;
        end else begin
            state_q  <= IDLE;
        end
    end

    // Decode the response byte from the registered state and the registered ack byte.
    always_comb begin
        // NOTE: assign a default first so that no path through the case leaves sdata unassigned and infers a latch.
        sdata = IDLE_CODE;
        case (state_q)
            ACK:     sdata = ~ack_q;
            NACK:    sdata = NACK_CODE;
            default: sdata = IDLE_CODE;
        endcase
    end

    assign slave_transfer.sdata = sdata;

`ifdef SLAVE_IO_CMD_COUNT_EN
    // Saturating counts of accepted command bytes. Refused or ignored bytes are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a5 <= 8'h00;
            cnt_c3 <= 8'h00;
        end else begin
            if (push_ok && (mdata == DATA_W'(CMD_A5)) && (cnt_a5 != 8'hFF)) begin
                cnt_a5 <= cnt_a5 + 8'd1;
            end
            if (push_ok && (mdata == DATA_W'(CMD_C3)) && (cnt_c3 != 8'hFF)) begin
                cnt_c3 <= cnt_c3 + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_slave_io.sv
// tb_slave_io: scoreboard bench for slave_io.
// A queue model of the FIFO predicts sdata, occupancy and the flags. Popped bytes go to a scoreboard and are compared when rd_valid appears.
module tb_slave_io;
    import slave_io_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_en;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
`ifdef SLAVE_IO_CMD_COUNT_EN
    logic [7:0] cnt_a5;
    logic [7:0] cnt_c3;
`endif

    data_transfer #(.DATA_W(8)) bus ();

    slave_io #(
        .DEPTH     (DEPTH),
        .DATA_W    (8),
        .NACK_CODE (8'hFF),
        .IDLE_CODE (8'h00)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .slave_transfer (bus),
        .sample_en      (sample_en),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .overflow       (overflow)
`ifdef SLAVE_IO_CMD_COUNT_EN
        ,
        .cnt_a5         (cnt_a5),
        .cnt_c3         (cnt_c3)
`endif
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;

    logic [7:0] mq[$];   // model FIFO contents
    logic [7:0] sb[$];   // expected popped bytes
    logic       m_ovf;
    logic [7:0] exp_sd;
    logic       exp_valid;
    int         m_a5;
    int         m_c3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model and compare after the edge.
    task automatic step(input logic se, input logic [7:0] md, input logic re);
        @(negedge clk);
        sample_en = se;
        bus.mdata = md;
        rd_en     = re;
        exp_valid = re && (mq.size() != 0);
        if (exp_valid) sb.push_back(mq.pop_front());
        if (!se) begin
            exp_sd = 8'h00;
        end else if (md == 8'hFF) begin
            exp_sd = 8'h00;
        end else if (mq.size() < DEPTH) begin
            mq.push_back(md);
            exp_sd = ~md;
            if (md == 8'hA5 && m_a5 < 255) m_a5++;
            if (md == 8'hC3 && m_c3 < 255) m_c3++;
        end else begin
            exp_sd = 8'hFF;
            m_ovf  = 1'b1;
        end
        @(posedge clk);
        #1;
        check("sdata",    bus.sdata, exp_sd);
        check("count",    count, mq.size());
        check("full",     full,  mq.size() == DEPTH);
        check("empty",    empty, mq.size() == 0);
        check("overflow", overflow, m_ovf);
        check("rd_valid", rd_valid, exp_valid);
        if (rd_valid && sb.size() != 0) check("rd_data", rd_data, sb.pop_front());
`ifdef SLAVE_IO_CMD_COUNT_EN
        check("cnt_a5", cnt_a5, m_a5);
        check("cnt_c3", cnt_c3, m_c3);
`endif
    endtask

    // Hold reset while a capture and a pop are requested. Both requests must be ignored.
    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst       = 1'b1;
        sample_en = 1'b1;
        bus.mdata = 8'hA5;
        rd_en     = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        mq.delete();
        sb.delete();
        m_ovf = 1'b0;
        m_a5  = 0;
        m_c3  = 0;
        check("rst_sdata",    bus.sdata, 8'h00);
        check("rst_count",    count, 0);
        check("rst_empty",    empty, 1'b1);
        check("rst_full",     full, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data",  rd_data, 8'h00);
`ifdef SLAVE_IO_CMD_COUNT_EN
        check("rst_cnt_a5", cnt_a5, 8'h00);
        check("rst_cnt_c3", cnt_c3, 8'h00);
`endif
        @(negedge clk);
        rst       = 1'b0;
        sample_en = 1'b0;
        rd_en     = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        sample_en = 1'b0;
        rd_en     = 1'b0;
        bus.mdata = 8'h00;
        m_ovf     = 1'b0;
        m_a5      = 0;
        m_c3      = 0;

        do_reset(2);

        // Ack path: sdata answers with the inverted byte, then returns to idle.
        push(8'hA5);
        push(8'hC3);
        step(1'b0, 8'h00, 1'b0);
        pop();
        pop();

        // Fill to full, then send a byte that must be refused.
        for (int i = 1; i <= 4; i++) push(8'(i));
        push(8'h05);
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) pop();
        pop();                               // pop on an empty FIFO is ignored

        // A reset with data in the FIFO discards that data.
        push(8'h21);
        push(8'h22);
        do_reset(1);

        // Full FIFO with a pop and a push in the same cycle accepts the byte.
        for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
        step(1'b1, 8'h06, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) pop();

        // The master idle pattern is not stored. On an empty FIFO, a same-cycle pop is ignored and the push goes in.
        push(8'hFF);
        step(1'b1, 8'h33, 1'b1);
        pop();

        // Random traffic, including idle patterns and overflow.
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom),
                 1'($urandom_range(0, 2) == 0));
        end

`ifdef SLAVE_IO_CMD_COUNT_EN
        do_reset(1);
        for (int i = 0; i < 300; i++) step(1'b1, 8'hA5, 1'b1);
        push(8'hC3);
        push(8'hC3);
        pop();
        do_reset(1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/slave_io.md
Name: slave_io

Overview:
- Responder end of the `data_transfer` interface.
- Samples the master's `mdata` on request and buffers accepted bytes in a small synchronous FIFO for local consumption.
- Drives an acknowledge/NACK response byte back on `sdata`.
- Sits opposite the master I/O block on the same `data_transfer` instance.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- DATA_W, 8, byte width; must match interface `mdata`/`sdata`.
- NACK_CODE, 8'hFF, `sdata` value when a byte is refused (FIFO full).
- IDLE_CODE, 8'h00, `sdata` value when no byte accepted or byte ignored.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  reset, synchronous active-high.
- slave_transfer  interface  data_transfer  reads `mdata` (DATA_W), drives `sdata` (DATA_W).
- sample_en  input  1  capture `slave_transfer.mdata` this cycle.
- rd_en  input  1  pop one FIFO entry.
- rd_data  output  DATA_W  popped byte, registered.
- rd_valid  output  1  `rd_data` valid, single-cycle pulse.
- count  output  $clog2(DEPTH)+1  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: a byte was refused while full.

Behaviour:
- Reset (`rst` high at posedge):
  - `sdata` = IDLE_CODE; `rd_data` = 0; `rd_valid` = 0; `count` = 0; `overflow` = 0.
  - Pointers = 0; `empty` = 1; `full` = 0.
  - Reset mid-operation discards all buffered data; pending `rd_en` and `sample_en` in that cycle are ignored.
- Capture, on `sample_en` at posedge, with mdata the value sampled:
  - mdata == 8'hFF (master reset/idle pattern): ignored; no push; `sdata` <= IDLE_CODE.
  - Otherwise, if not full (after any same-cycle pop): push mdata; `sdata` <= ~mdata. So 8'hA5 acks 8'h5A and 8'hC3 acks 8'h3C.
  - Otherwise (full, no pop): byte dropped; `sdata` <= NACK_CODE; `overflow` <= 1.
- No `sample_en`: `sdata` <= IDLE_CODE.
- `sdata` latency: exactly one cycle after the sampling edge, held for one cycle only.
- Read:
  - `rd_en` when not empty: `rd_data` <= head entry and `rd_valid` <= 1 next cycle.
  - `rd_en` when empty: ignored; `rd_valid` stays 0; no underflow flag.
- Simultaneous push and pop:
  - Pop is evaluated first, so a full FIFO with `rd_en` accepts the new byte.
  - `count` is unchanged; no NACK, no overflow.
  - When empty, the same-cycle pushed byte is NOT returned that cycle: pop is ignored and the byte is pushed.
- Pointers wrap modulo DEPTH. `count` is the sole full/empty source.
- `full`, `empty` and `count` are combinational from the count register; all other outputs are registered.
- `overflow` clears only on `rst`.
- Internal FSM (drives `sdata`):
  - States: IDLE, ACK, NACK.
  - Any state → ACK on an accepted push, → NACK on a refused byte, → IDLE otherwise.
  - `sdata` is decoded from the registered state plus the registered ack byte.

Optional Feature:
- Macro: SLAVE_IO_CMD_COUNT_EN.
- Defined:
  - Adds outputs `cnt_a5` [7:0] and `cnt_c3` [7:0], both reset to 0.
  - Each increments when an accepted (pushed) byte equals 8'hA5 or 8'hC3 respectively.
  - Both saturate at 8'hFF; refused and ignored bytes are not counted.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package `slave_io_pkg`:
  - CMD_A5 = 8'hA5, CMD_C3 = 8'hC3, MASTER_IDLE = 8'hFF.
  - Default NACK/IDLE codes.
  - `typedef enum logic [1:0] {IDLE, ACK, NACK} slave_state_t`.
- One sub-module, `slave_fifo`:
  - Parameterised DEPTH/DATA_W synchronous FIFO with push/pop/count/full/empty.
  - Implements the pop-before-push rule.
- `slave_io` owns the capture logic, FSM, `sdata` and `overflow`.

Test Plan:
- Reset: hold `rst` 2 cycles with `mdata`=8'hA5 and `sample_en`=1 → `sdata`=8'h00, `count`=0, `empty`=1, `overflow`=0.
- Ack path: `mdata`=8'hA5 with `sample_en` 1 cycle, then 8'hC3 → `sdata`=8'h5A then 8'h3C on following cycles; `count`=2. Two `rd_en` pulses → `rd_data` 8'hA5 then 8'hC3, each with `rd_valid`=1.
- Full/NACK: push 8'h01..8'h04 (DEPTH=4) → `full`=1. Push 8'h05 → `sdata`=8'hFF, `overflow`=1 and stays 1. Popping yields 01..04 only.
- Full with simultaneous `rd_en` + `sample_en`(8'h06) → `rd_data`=head, `sdata`=8'hF9, `count` stays 4, no `overflow`.
- Idle pattern and empty pop: `sample_en` with `mdata`=8'hFF → no push, `sdata`=8'h00. `rd_en` on empty → `rd_valid`=0, `count`=0.
- With SLAVE_IO_CMD_COUNT_EN: 300 accepted 8'hA5 pushes, popped continuously → `cnt_a5`=8'hFF (saturated), `cnt_c3`=0. Assert `rst` mid-sequence → both 0 and FIFO empty.
